// File: rtl/mult_datapath_pkg.sv
// Shared strobe decoding for the sequential multiplier datapath.
// Collapses Load/Ad/Sh into one prioritised operation per cycle.
package mult_datapath_pkg;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_ADD,
        OP_SHIFT,
        OP_ADD_SHIFT
    } dp_op_e;

    // Load dominates, so a Load cycle never also adds or shifts.
    function automatic dp_op_e decode_op(input logic load, input logic ad, input logic sh);
        if (load)           return OP_LOAD;
        else if (ad && sh)  return OP_ADD_SHIFT;
        else if (ad)        return OP_ADD;
        else if (sh)        return OP_SHIFT;
        else                return OP_HOLD;
    endfunction

endpackage

// File: rtl/mult_shift_counter.sv
// Shift counter for the multiplier: counts Sh strobes modulo N and flags the
// last shift of an operation on K.
module mult_shift_counter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clr,
    input  logic Inc,
    output logic K
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (Clr)
            cnt_d = '0;
        else if (Inc)
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    // NOTE: non-blocking for state so all registers see pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign K = (cnt_q == LAST);

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add datapath of the unsigned sequential multiplier: operand
// registers, the 2N+1 bit accumulator/multiplier register and the shift counter.
module mult_datapath
    import mult_datapath_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Load,
    input  logic           Ad,
    input  logic           Sh,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    logic [2*N:0] acc_q, acc_d;
    logic [N-1:0] mc_q, mc_d;
    logic [N:0]   sum;

    // ACC[2N] is always clear before an add, so the sum ignores it.
    assign sum = {1'b0, acc_q[2*N-1:N]} + {1'b0, mc_q};

    always_comb begin
        acc_d = acc_q;
        mc_d  = mc_q;
        unique case (decode_op(Load, Ad, Sh))
            OP_LOAD: begin
                mc_d  = Mcand;
                acc_d = {{(N+1){1'b0}}, Mplier};
            end
            OP_ADD_SHIFT: acc_d = {1'b0, sum, acc_q[N-1:1]};
            OP_ADD:       acc_d = {sum, acc_q[N-1:0]};
            OP_SHIFT:     acc_d = acc_q >> 1;
            default:      ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc_q <= '0;
            mc_q  <= '0;
        end else begin
            acc_q <= acc_d;
            mc_q  <= mc_d;
        end
    end

    mult_shift_counter #(.N(N), .CW(CW)) u_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .Clr   (Load),
        .Inc   (Sh),
        .K     (K)
    );

    assign M       = acc_q[0];
    assign Product = acc_q[2*N-1:0];

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against N=4 and N=8 instances.
module tb_mult_datapath;

    logic       clk = 1'b0;
    logic       reset;
    logic       load4, ad4, sh4, m4, k4;
    logic [3:0] mcand4, mplier4;
    logic [7:0] product4;
    logic       load8, ad8, sh8, m8, k8;
    logic [7:0] mcand8, mplier8;
    logic [15:0] product8;

    always #5 clk = ~clk;

    mult_datapath #(.N(4)) dut4 (
        .Clk(clk), .Reset(reset), .Load(load4), .Ad(ad4), .Sh(sh4),
        .Mcand(mcand4), .Mplier(mplier4), .M(m4), .K(k4), .Product(product4)
    );

    mult_datapath #(.N(8)) dut8 (
        .Clk(clk), .Reset(reset), .Load(load8), .Ad(ad8), .Sh(sh8),
        .Mcand(mcand8), .Mplier(mplier8), .M(m8), .K(k8), .Product(product8)
    );

    typedef struct {
        string       name;
        int          sel;
        bit          chk_p;
        logic [15:0] p;
        bit          chk_k;
        logic        k;
        bit          chk_m;
        logic        m;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.chk_p) check({e.name, " product"}, (e.sel == 8) ? product8 : {8'h00, product4}, e.p);
            if (e.chk_k) check({e.name, " K"}, {15'h0, (e.sel == 8) ? k8 : k4}, {15'h0, e.k});
            if (e.chk_m) check({e.name, " M"}, {15'h0, (e.sel == 8) ? m8 : m4}, {15'h0, e.m});
        end
    end

    task automatic expect_now(input string name, input int sel,
                              input bit cp, input logic [15:0] p,
                              input bit ck, input logic k,
                              input bit cm, input logic m);
        exp_t e;
        e.name = name; e.sel = sel;
        e.chk_p = cp; e.p = p; e.chk_k = ck; e.k = k; e.chk_m = cm; e.m = m;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input bit l, input bit a, input bit s);
        if (sel == 8) begin load8 = l; ad8 = a; sh8 = s; end
        else          begin load4 = l; ad4 = a; sh4 = s; end
    endtask

    task automatic set_ops(input int sel, input logic [7:0] mc, input logic [7:0] mp);
        if (sel == 8) begin mcand8 = mc; mplier8 = mp; end
        else          begin mcand4 = mc[3:0]; mplier4 = mp[3:0]; end
    endtask

    function automatic logic cur_m(input int sel);
        return (sel == 8) ? m8 : m4;
    endfunction

    // FSM-style sequence: Load, then N x (Ad-if-M cycle, Sh cycle).
    // Operand inputs are scrambled after the load; they must have no effect.
    task automatic load_op(input int sel, input logic [7:0] mc, input logic [7:0] mp);
        set_ops(sel, mc, mp);
        drive(sel, 1, 0, 0);
        tick();
        set_ops(sel, ~mc, ~mp);
    endtask

    task automatic iterate(input string name, input int sel, input int first, input int last,
                           input bit expect_m0, input int probe_iter, input logic [15:0] probe_val);
        for (int i = first; i <= last; i++) begin
            if (expect_m0) expect_now($sformatf("%s it%0d", name, i), sel, 0, '0, 0, 0, 1, 1'b0);
            drive(sel, 0, cur_m(sel), 0);
            tick();
            expect_now($sformatf("%s sh%0d", name, i), sel, (i == probe_iter), probe_val,
                       1, (i == sel - 1), 0, 1'b0);
            drive(sel, 0, 0, 1);
            tick();
        end
        drive(sel, 0, 0, 0);
    endtask

    task automatic run_mult(input string name, input int sel, input logic [7:0] mc, input logic [7:0] mp,
                            input logic [15:0] result, input bit expect_m0,
                            input int probe_iter, input logic [15:0] probe_val);
        load_op(sel, mc, mp);
        iterate(name, sel, 0, sel - 1, expect_m0, probe_iter, probe_val);
        expect_now({name, " done"}, sel, 1, result, 1, 1'b0, 0, 1'b0);
        tick();
        expect_now({name, " hold"}, sel, 1, result, 0, 1'b0, 0, 1'b0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(4, 0, 0, 0); drive(8, 0, 0, 0);
        set_ops(4, 8'h0, 8'h0); set_ops(8, 8'h0, 8'h0);
        tick();
        expect_now("reset4", 4, 1, 16'h0, 1, 1'b0, 1, 1'b0);
        expect_now("reset8", 8, 1, 16'h0, 1, 1'b0, 1, 1'b0);
        tick();
        reset = 1'b0;

        run_mult("13x11", 4, 8'd13, 8'd11, 16'd143, 0, -1, '0);
        // 15x15: after the second add ACC = 1_0110_1111, carry lands above the product.
        run_mult("15x15", 4, 8'd15, 8'd15, 16'd225, 0, 1, 16'h006F);
        run_mult("9x0", 4, 8'd9, 8'd0, 16'd0, 1, -1, '0);
        run_mult("0x7", 4, 8'd0, 8'd7, 16'd0, 0, -1, '0);

        // Reset mid-multiply after the second shift, then a clean restart.
        load_op(4, 8'd13, 8'd11);
        iterate("13x11 part", 4, 0, 1, 0, -1, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_now("mid reset", 4, 1, 16'h0, 1, 1'b0, 1, 1'b0);
        tick();
        run_mult("6x7", 4, 8'd6, 8'd7, 16'd42, 0, -1, '0);

        // Load with Ad and Sh in the same cycle: only the load acts.
        set_ops(4, 8'd5, 8'd3);
        drive(4, 1, 1, 1);
        tick();
        set_ops(4, 8'd10, 8'd12);
        drive(4, 0, 0, 0);
        expect_now("load prio", 4, 1, 16'd3, 1, 1'b0, 1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_now($sformatf("addsh%0d", i), 4, 0, '0, 1, (i == 3), 0, 1'b0);
            drive(4, 0, m4, 1);
            tick();
        end
        drive(4, 0, 0, 0);
        expect_now("5x3 addsh", 4, 1, 16'd15, 1, 1'b0, 0, 1'b0);
        tick();

        run_mult("255x255", 8, 8'd255, 8'd255, 16'd65025, 0, -1, '0);

        tick();
        tick();
        check("scoreboard drained", 16'(sb_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
